// File: rtl/inst_prefetch_queue_if.sv
// Fetch/decode handshake bundle for inst_prefetch_queue.
// master = prefetch queue side, slave = ROM/decoder/control side.
interface inst_prefetch_queue_if #(
  parameter int W = 9,
  parameter int A = 10
);
  logic         Start;
  logic [A-1:0] RomAddr;
  logic [W-1:0] RomData;
  logic [W-1:0] InstOut;
  logic [A-1:0] InstPC;
  logic         InstValid;
  logic         InstReady;
  logic         Redirect;
  logic [A-1:0] RedirectPC;
  logic         FetchHalted;

  modport master (
    input  Start, RomData, InstReady,
    input  Redirect, RedirectPC,
    output RomAddr, InstOut, InstPC,
    output InstValid, FetchHalted
  );

  modport slave (
    output Start, RomData, InstReady,
    output Redirect, RedirectPC,
    input  RomAddr, InstOut, InstPC,
    input  InstValid, FetchHalted
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns fetch PC, buffers {PC,inst} pairs.
// Optional flush counter port FlushCt enabled by PREFETCH_FLUSH_CNT_EN.
module inst_prefetch_queue #(
  parameter int W     = 9,
  parameter int A     = 10,
  parameter int DEPTH = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  inst_prefetch_queue_if.master bus
`ifdef PREFETCH_FLUSH_CNT_EN
  ,
  output logic [15:0] FlushCt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STOP
  } state_e;

  typedef struct packed {
    logic [A-1:0] pc;
    logic [W-1:0] ins;
  } entry_t;

  state_e        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic flush_start;
  logic flush_redir;
  logic flush;
  logic push;
  logic pop;
  entry_t head;

  always_comb begin
    flush_start = bus.Start;
    flush_redir = bus.Redirect && (state_q != IDLE);
    flush       = flush_start || flush_redir;
    pop         = (cnt_q != '0) && bus.InstReady && !flush;
    push        = (state_q == FETCH) && !flush &&
                  ((cnt_q != CW'(DEPTH)) || pop);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    if (flush_start) begin
      state_d = FETCH;
      pc_d    = '0;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
    end else if (flush_redir) begin
      state_d = FETCH;
      pc_d    = bus.RedirectPC;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = '{pc: pc_q, ins: bus.RomData};
        wr_d        = wr_q + PW'(1);
        pc_d        = pc_q + A'(1);
        if (&bus.RomData) state_d = STOP;
      end
      if (pop) rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  // Outputs are forced to zero when empty so stale slots never leak.
  always_comb begin
    head            = mem_q[rd_q];
    bus.InstValid   = (cnt_q != '0);
    bus.InstOut     = bus.InstValid ? head.ins : '0;
    bus.InstPC      = bus.InstValid ? head.pc : '0;
    bus.RomAddr     = pc_q;
    bus.FetchHalted = (state_q == STOP);
  end

`ifdef PREFETCH_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [16:0] flush_sum;

  always_comb begin
    flush_sum   = {1'b0, flush_cnt_q} + 17'(cnt_q);
    flush_cnt_d = flush_cnt_q;
    if (flush) flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) flush_cnt_q <= '0;
    else          flush_cnt_q <= flush_cnt_d;
  end

  assign FlushCt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a combinational ROM model.
// Build with PREFETCH_FLUSH_CNT_EN to also cover FlushCt.
module tb_inst_prefetch_queue;

  logic Clk;
  logic Reset_n;
  logic [8:0] rom [1024];
  int n_chk;
  int n_fail;

  inst_prefetch_queue_if #(.W(9), .A(10)) bus ();

`ifdef PREFETCH_FLUSH_CNT_EN
  logic [15:0] FlushCt;
  logic [15:0] fc0;
`endif

  inst_prefetch_queue #(
    .W(9),
    .A(10),
    .DEPTH(4)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
`ifdef PREFETCH_FLUSH_CNT_EN
    ,
    .FlushCt(FlushCt)
`endif
  );

  assign bus.RomData = rom[bus.RomAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'(i + 1);
    Reset_n        = 1'b0;
    bus.Start      = 1'b0;
    bus.InstReady  = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = '0;
    #3;
    chk("rst_valid", 32'(bus.InstValid), 0);
    chk("rst_out", 32'(bus.InstOut), 0);
    chk("rst_pc", 32'(bus.InstPC), 0);
    chk("rst_romaddr", 32'(bus.RomAddr), 0);
    chk("rst_halt", 32'(bus.FetchHalted), 0);
`ifdef PREFETCH_FLUSH_CNT_EN
    chk("rst_flushct", 32'(FlushCt), 0);
`endif
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    tick();
    chk("idle_valid", 32'(bus.InstValid), 0);
    chk("idle_romaddr", 32'(bus.RomAddr), 0);

    // Start with ready high: valid two cycles after, one per cycle.
    bus.Start     = 1'b1;
    bus.InstReady = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("t1_bubble_valid", 32'(bus.InstValid), 0);
    chk("t1_bubble_addr", 32'(bus.RomAddr), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_valid", 32'(bus.InstValid), 1);
      chk("t1_out", 32'(bus.InstOut), 32'(9'(i + 1)));
      chk("t1_pc", 32'(bus.InstPC), 32'(i));
    end

    // Ready low: fill to DEPTH, then drain in order without gaps.
    bus.InstReady = 1'b0;
    bus.Start     = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (6) tick();
    chk("t2_full_addr", 32'(bus.RomAddr), 4);
    chk("t2_full_pc", 32'(bus.InstPC), 0);
    chk("t2_full_out", 32'(bus.InstOut), 1);
    tick();
    chk("t2_hold_addr", 32'(bus.RomAddr), 4);
    bus.InstReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 32'(bus.InstValid), 1);
      chk("t2_pc", 32'(bus.InstPC), 32'(i));
      tick();
    end

    // Redirect with three entries queued and a same-cycle pop.
    bus.InstReady = 1'b0;
    bus.Start     = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (3) tick();
    chk("t3_three_addr", 32'(bus.RomAddr), 3);
`ifdef PREFETCH_FLUSH_CNT_EN
    fc0 = FlushCt;
`endif
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 10'h200;
    bus.InstReady  = 1'b1;
    tick();
    bus.Redirect = 1'b0;
    chk("t3_flush_valid", 32'(bus.InstValid), 0);
    chk("t3_flush_addr", 32'(bus.RomAddr), 32'h200);
`ifdef PREFETCH_FLUSH_CNT_EN
    chk("t3_flushct", 32'(FlushCt), 32'(fc0) + 3);
`endif
    tick();
    chk("t3_pc", 32'(bus.InstPC), 32'h200);
    chk("t3_out", 32'(bus.InstOut), 32'(rom[10'h200]));

    // Halt word at address 5 stops fetching; queue drains.
    rom[5]    = 9'h1FF;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_pc", 32'(bus.InstPC), 32'(i));
      if (i == 5) begin
        chk("t4_halt_word", 32'(bus.InstOut), 32'h1FF);
        chk("t4_halted", 32'(bus.FetchHalted), 1);
      end
    end
    tick();
    chk("t4_drained", 32'(bus.InstValid), 0);
    chk("t4_stop_addr", 32'(bus.RomAddr), 6);
    chk("t4_halted2", 32'(bus.FetchHalted), 1);
    repeat (2) tick();
    chk("t4_still_empty", 32'(bus.InstValid), 0);
    chk("t4_still_addr", 32'(bus.RomAddr), 6);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 10'h020;
    tick();
    bus.Redirect = 1'b0;
    rom[5]       = 9'h006;
    chk("t4_resume_halt", 32'(bus.FetchHalted), 0);
    chk("t4_resume_addr", 32'(bus.RomAddr), 32'h020);
    tick();
    chk("t4_resume_pc", 32'(bus.InstPC), 32'h020);

    // PC wrap-around from the top of the address space.
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 10'h3FF;
    tick();
    bus.Redirect = 1'b0;
    tick();
    chk("t5_pc_3ff", 32'(bus.InstPC), 32'h3FF);
    tick();
    chk("t5_pc_000", 32'(bus.InstPC), 0);
    tick();
    chk("t5_pc_001", 32'(bus.InstPC), 1);
    chk("t5_out_001", 32'(bus.InstOut), 32'(rom[1]));

    // Fill to full with ready low, then async reset mid-cycle.
    bus.InstReady = 1'b0;
    repeat (6) tick();
    chk("t6_full_addr", 32'(bus.RomAddr), 5);
    chk("t6_full_pc", 32'(bus.InstPC), 1);
    tick();
    chk("t6_hold_addr", 32'(bus.RomAddr), 5);
    chk("t6_hold_pc", 32'(bus.InstPC), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.InstValid), 0);
    chk("t6_rst_out", 32'(bus.InstOut), 0);
    chk("t6_rst_pc", 32'(bus.InstPC), 0);
    chk("t6_rst_addr", 32'(bus.RomAddr), 0);
    chk("t6_rst_halt", 32'(bus.FetchHalted), 0);
`ifdef PREFETCH_FLUSH_CNT_EN
    chk("t6_rst_flushct", 32'(FlushCt), 0);
`endif
    @(negedge Clk);
    Reset_n       = 1'b1;
    bus.InstReady = 1'b1;
    repeat (3) tick();
    chk("t6_idle_valid", 32'(bus.InstValid), 0);
    chk("t6_idle_addr", 32'(bus.RomAddr), 0);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 10'h055;
    tick();
    bus.Redirect = 1'b0;
    tick();
    chk("t6_idle_redir_addr", 32'(bus.RomAddr), 0);
    chk("t6_idle_redir_valid", 32'(bus.InstValid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
